dma_chan_addr_datapath: RTL and testbench

- Parametrised successor to the single-buffer DMA datapath.
- Holds per-channel base/current address and base/current word-count registers, programmed byte-serially over DB through a byte-pointer flip-flop.
- In active mode (HLDA high) it presents the selected channel's current address and advances address/count per transfer strobe, raising terminal count with optional autoinitialise.
- Sits between the bus interface and the timing/control FSM.

---
 rtl/dma_chan_addr_datapath.sv | 173 +++++++++++++++++
 tb/tb_dma_chan_addr_datapath.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_chan_addr_datapath.sv
// Multi-channel DMA address/count datapath: byte-serial register programming over DB
// in program mode, per-transfer address/count stepping with terminal count in active mode.
module dma_chan_addr_datapath #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CS_N,
   input  logic              IOW_N,
   input  logic              IOR_N,
   input  logic [3:0]        ADDR_L,
   input  logic [DATA_W-1:0] DB_IN,
   output logic [DATA_W-1:0] DB_OUT,
   output logic              DB_OE,
   input  logic              HLDA,
   input  logic [1:0]        ACT_CH,
   input  logic              XFER,
   input  logic [NUM_CH-1:0] MODE_DEC,
   input  logic [NUM_CH-1:0] MODE_AUTO,
   output logic [ADDR_W-1:0] ADDR_OUT,
   output logic              TC,
   output logic              BP_OUT
);

   localparam int BYTES = ADDR_W / 8;
   localparam int PW    = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(BYTES - 1);

   // Register file is always four slots deep; slots at or above NUM_CH are never written.
   logic [ADDR_W-1:0] r_baseAddr [4];
   logic [ADDR_W-1:0] r_curAddr  [4];
   logic [ADDR_W-1:0] r_baseCnt  [4];
   logic [ADDR_W-1:0] r_curCnt   [4];

   logic [PW-1:0]     r_ptr;
   logic              r_iowPrev;
   logic              r_iorPrev;
   logic              r_tc;
   logic [DATA_W-1:0] r_dbOut;
   logic              r_dbOe;

   logic              w_progMode;
   logic              w_wrAcc;
   logic              w_rdAcc;
   logic              w_isSlot;
   logic [1:0]        w_slotCh;
   logic              w_slotValid;
   logic              w_actValid;
   logic              w_xferValid;
   logic [PW-1:0]     w_ptrNext;
   logic [ADDR_W-1:0] w_rdReg;
   logic [7:0]        w_rdByte;
   logic [3:0]        w_dec4;
   logic [3:0]        w_auto4;
   logic [ADDR_W-1:0] w_curA;
   logic [ADDR_W-1:0] w_curC;
   logic [ADDR_W-1:0] w_stepAddr;

   assign w_progMode  = !CS_N && !HLDA;
   assign w_wrAcc     = w_progMode && !IOW_N && r_iowPrev;
   assign w_rdAcc     = w_progMode && !IOR_N && r_iorPrev && !w_wrAcc;
   assign w_isSlot    = !ADDR_L[3];
   assign w_slotCh    = ADDR_L[2:1];
   assign w_slotValid = w_isSlot && ({1'b0, w_slotCh} < 3'(NUM_CH));
   assign w_actValid  = HLDA && ({1'b0, ACT_CH} < 3'(NUM_CH));
   assign w_xferValid = w_actValid && XFER;
   assign w_ptrNext   = (r_ptr == LAST_PTR) ? '0 : r_ptr + PW'(1);

   assign w_curA      = r_curAddr[ACT_CH];
   assign w_curC      = r_curCnt[ACT_CH];
   assign w_stepAddr  = w_dec4[ACT_CH] ? w_curA - ADDR_W'(1) : w_curA + ADDR_W'(1);

   always_comb begin
      w_dec4               = '0;
      w_auto4              = '0;
      w_dec4[NUM_CH-1:0]   = MODE_DEC;
      w_auto4[NUM_CH-1:0]  = MODE_AUTO;
   end

   always_comb begin
      w_rdByte = '0;
      w_rdReg  = ADDR_L[0] ? r_curCnt[w_slotCh] : r_curAddr[w_slotCh];
      for (int b = 0; b < BYTES; b++) begin
         if (r_ptr == PW'(b)) w_rdByte = w_rdReg[b*8 +: 8];
      end
      if (!w_slotValid) w_rdByte = '0;
   end

   // Programming and transfer stepping never coincide: program mode requires HLDA low.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < 4; i++) begin
            r_baseAddr[i] <= '0;
            r_curAddr[i]  <= '0;
            r_baseCnt[i]  <= '0;
            r_curCnt[i]   <= '0;
         end
         r_ptr <= '0;
         r_tc  <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (w_wrAcc) begin
            if (ADDR_L == 4'hD) begin
               for (int i = 0; i < 4; i++) begin
                  r_baseAddr[i] <= '0;
                  r_curAddr[i]  <= '0;
                  r_baseCnt[i]  <= '0;
                  r_curCnt[i]   <= '0;
               end
               r_ptr <= '0;
            end else if (ADDR_L == 4'hC) begin
               r_ptr <= '0;
            end else if (w_isSlot) begin
               if (w_slotValid) begin
                  for (int b = 0; b < BYTES; b++) begin
                     if (r_ptr == PW'(b)) begin
                        if (ADDR_L[0]) begin
                           r_baseCnt[w_slotCh][b*8 +: 8] <= DB_IN[7:0];
                           r_curCnt[w_slotCh][b*8 +: 8]  <= DB_IN[7:0];
                        end else begin
                           r_baseAddr[w_slotCh][b*8 +: 8] <= DB_IN[7:0];
                           r_curAddr[w_slotCh][b*8 +: 8]  <= DB_IN[7:0];
                        end
                     end
                  end
               end
               r_ptr <= w_ptrNext;
            end
         end else if (w_rdAcc && w_isSlot) begin
            r_ptr <= w_ptrNext;
         end

         // A zero count before the transfer is terminal; decrementing it wraps to all ones.
         if (w_xferValid) begin
            r_tc <= (w_curC == '0);
            if ((w_curC == '0) && w_auto4[ACT_CH]) begin
               r_curAddr[ACT_CH] <= r_baseAddr[ACT_CH];
               r_curCnt[ACT_CH]  <= r_baseCnt[ACT_CH];
            end else begin
               r_curAddr[ACT_CH] <= w_stepAddr;
               r_curCnt[ACT_CH]  <= w_curC - ADDR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_iowPrev <= 1'b1;
         r_iorPrev <= 1'b1;
         r_dbOut   <= '0;
         r_dbOe    <= 1'b0;
      end else begin
         r_iowPrev <= IOW_N;
         r_iorPrev <= IOR_N;
         r_dbOe    <= w_progMode && !IOR_N;
         if (w_rdAcc) begin
            r_dbOut <= DATA_W'(w_rdByte);
         end else if (IOR_N) begin
            r_dbOut <= '0;
         end
      end
   end

   assign ADDR_OUT = w_actValid ? r_curAddr[ACT_CH] : '0;
   assign TC       = r_tc;
   assign BP_OUT   = (r_ptr != '0);
   assign DB_OUT   = r_dbOut;
   assign DB_OE    = r_dbOe;

endmodule

// File: tb/tb_dma_chan_addr_datapath.sv
// Directed self-checking bench for dma_chan_addr_datapath (NUM_CH=4, ADDR_W=16):
// register programming/readback table plus hand-written transfer and strobe sequences.
module tb_dma_chan_addr_datapath;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   logic              CLK;
   logic              RESET;
   logic              CS_N;
   logic              IOW_N;
   logic              IOR_N;
   logic [3:0]        ADDR_L;
   logic [DATA_W-1:0] DB_IN;
   logic [DATA_W-1:0] DB_OUT;
   logic              DB_OE;
   logic              HLDA;
   logic [1:0]        ACT_CH;
   logic              XFER;
   logic [NUM_CH-1:0] MODE_DEC;
   logic [NUM_CH-1:0] MODE_AUTO;
   logic [ADDR_W-1:0] ADDR_OUT;
   logic              TC;
   logic              BP_OUT;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] wrVal;
      logic        expBp;
      logic [15:0] expRd;
   } vec_t;

   vec_t vecs[10];

   dma_chan_addr_datapath #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .IOW_N(IOW_N), .IOR_N(IOR_N),
      .ADDR_L(ADDR_L), .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
      .HLDA(HLDA), .ACT_CH(ACT_CH), .XFER(XFER), .MODE_DEC(MODE_DEC),
      .MODE_AUTO(MODE_AUTO), .ADDR_OUT(ADDR_OUT), .TC(TC), .BP_OUT(BP_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic regWrite(input logic [3:0] addr, input logic [7:0] data);
      ADDR_L = addr;
      DB_IN  = data;
      CS_N   = 1'b0;
      IOW_N  = 1'b0;
      tick();
      IOW_N  = 1'b1;
      CS_N   = 1'b1;
      tick();
   endtask

   task automatic regRead(input logic [3:0] addr, output logic [7:0] data);
      ADDR_L = addr;
      CS_N   = 1'b0;
      IOR_N  = 1'b0;
      tick();
      data   = DB_OUT;
      IOR_N  = 1'b1;
      CS_N   = 1'b1;
      tick();
   endtask

   task automatic program16(input logic [3:0] addr, input logic [15:0] value);
      regWrite(4'hC, 8'h00);
      regWrite(addr, value[7:0]);
      regWrite(addr, value[15:8]);
   endtask

   task automatic read16(input logic [3:0] addr, output logic [15:0] value);
      logic [7:0] lo;
      logic [7:0] hi;
      regWrite(4'hC, 8'h00);
      regRead(addr, lo);
      regRead(addr, hi);
      value = {hi, lo};
   endtask

   task automatic pulseXfer();
      XFER = 1'b1;
      tick();
      XFER = 1'b0;
   endtask

   // Each record: clear pointer, write two bytes, then read back both bytes of the current register.
   task automatic applyStimulus(input vec_t v, input int idx);
      logic [15:0] rd;
      regWrite(4'hC, 8'h00);
      regWrite(v.addr, v.wrVal[7:0]);
      checkOutput($sformatf("vec%0d bp after first byte", idx), 32'(BP_OUT), 32'(v.expBp));
      regWrite(v.addr, v.wrVal[15:8]);
      read16(v.addr, rd);
      checkOutput($sformatf("vec%0d readback addr 0x%0h", idx, v.addr), 32'(rd), 32'(v.expRd));
   endtask

   initial begin
      logic [15:0] rd16;

      vecs[0] = '{4'h0, 16'hBEEF, 1'b1, 16'hBEEF};
      vecs[1] = '{4'h1, 16'h1357, 1'b1, 16'h1357};
      vecs[2] = '{4'h2, 16'h2468, 1'b1, 16'h2468};
      vecs[3] = '{4'h3, 16'hFFFF, 1'b1, 16'hFFFF};
      vecs[4] = '{4'h4, 16'h0F0F, 1'b1, 16'h0F0F};
      vecs[5] = '{4'h5, 16'h8001, 1'b1, 16'h8001};
      vecs[6] = '{4'h6, 16'hC0DE, 1'b1, 16'hC0DE};
      vecs[7] = '{4'h7, 16'h00A5, 1'b1, 16'h00A5};
      vecs[8] = '{4'h9, 16'h1111, 1'b0, 16'h0000};
      vecs[9] = '{4'hE, 16'h2222, 1'b0, 16'h0000};

      RESET = 1'b1; CS_N = 1'b1; IOW_N = 1'b1; IOR_N = 1'b1;
      ADDR_L = '0; DB_IN = '0; HLDA = 1'b0; ACT_CH = '0; XFER = 1'b0;
      MODE_DEC = '0; MODE_AUTO = '0;
      tick();
      tick();

      checkOutput("reset DB_OUT", 32'(DB_OUT), 32'h0);
      checkOutput("reset DB_OE", 32'(DB_OE), 32'h0);
      checkOutput("reset TC", 32'(TC), 32'h0);
      checkOutput("reset BP_OUT", 32'(BP_OUT), 32'h0);
      HLDA = 1'b1;
      #1;
      checkOutput("reset ADDR_OUT", 32'(ADDR_OUT), 32'h0);
      HLDA = 1'b0;
      RESET = 1'b0;
      tick();

      // Two-byte address write with byte pointer toggling
      regWrite(4'h2, 8'h34);
      checkOutput("plan1 bp after lsb", 32'(BP_OUT), 32'h1);
      regWrite(4'h2, 8'h12);
      checkOutput("plan1 bp after msb", 32'(BP_OUT), 32'h0);
      HLDA = 1'b1; ACT_CH = 2'd1;
      #1;
      checkOutput("plan1 ch1 addr", 32'(ADDR_OUT), 32'h1234);
      HLDA = 1'b0;
      tick();

      // Clear-pointer in the middle of a sequence restarts at LSB
      regWrite(4'h2, 8'h34);
      regWrite(4'hC, 8'hFF);
      checkOutput("plan2 bp after clear", 32'(BP_OUT), 32'h0);
      regWrite(4'h2, 8'h56);
      regWrite(4'h2, 8'h78);
      HLDA = 1'b1; ACT_CH = 2'd1;
      #1;
      checkOutput("plan2 ch1 addr", 32'(ADDR_OUT), 32'h7856);

      // Strobes while HLDA high must be ignored
      regWrite(4'h2, 8'hEE);
      checkOutput("hlda write bp", 32'(BP_OUT), 32'h0);
      checkOutput("hlda write addr", 32'(ADDR_OUT), 32'h7856);
      HLDA = 1'b0;
      tick();

      // Increment across byte boundary, TC on count underflow
      program16(4'h0, 16'h00FF);
      program16(4'h1, 16'h0001);
      HLDA = 1'b1; ACT_CH = 2'd0;
      #1;
      checkOutput("plan3 start addr", 32'(ADDR_OUT), 32'h00FF);
      pulseXfer();
      checkOutput("plan3 addr xfer1", 32'(ADDR_OUT), 32'h0100);
      checkOutput("plan3 tc xfer1", 32'(TC), 32'h0);
      pulseXfer();
      checkOutput("plan3 addr xfer2", 32'(ADDR_OUT), 32'h0101);
      checkOutput("plan3 tc xfer2", 32'(TC), 32'h1);
      tick();
      checkOutput("plan3 tc drops", 32'(TC), 32'h0);
      HLDA = 1'b0;
      read16(4'h1, rd16);
      checkOutput("plan3 count wrapped", 32'(rd16), 32'hFFFF);

      // Decrement wraps address below zero; autoinitialise reload
      MODE_DEC = 4'b1100; MODE_AUTO = 4'b0100;
      program16(4'h6, 16'h0000);
      program16(4'h7, 16'h0005);
      program16(4'h4, 16'h1000);
      program16(4'h5, 16'h0000);
      HLDA = 1'b1; ACT_CH = 2'd3;
      pulseXfer();
      checkOutput("dec wrap addr", 32'(ADDR_OUT), 32'hFFFF);
      checkOutput("dec wrap tc", 32'(TC), 32'h0);
      ACT_CH = 2'd2;
      pulseXfer();
      checkOutput("plan4 reload addr", 32'(ADDR_OUT), 32'h1000);
      checkOutput("plan4 tc", 32'(TC), 32'h1);
      HLDA = 1'b0;
      read16(4'h5, rd16);
      checkOutput("plan4 reload count", 32'(rd16), 32'h0000);
      read16(4'h7, rd16);
      checkOutput("dec count", 32'(rd16), 32'h0004);

      // Held read strobe: one access, DB_OE one cycle behind
      program16(4'h1, 16'hABCD);
      regWrite(4'hC, 8'h00);
      ADDR_L = 4'h1; CS_N = 1'b0; IOR_N = 1'b0;
      #1;
      checkOutput("plan5 oe before edge", 32'(DB_OE), 32'h0);
      tick();
      checkOutput("plan5 lsb data", 32'(DB_OUT), 32'hCD);
      checkOutput("plan5 oe after edge", 32'(DB_OE), 32'h1);
      tick();
      tick();
      checkOutput("plan5 lsb held", 32'(DB_OUT), 32'hCD);
      checkOutput("plan5 bp no double", 32'(BP_OUT), 32'h1);
      IOR_N = 1'b1;
      tick();
      checkOutput("plan5 oe released", 32'(DB_OE), 32'h0);
      IOR_N = 1'b0;
      tick();
      checkOutput("plan5 msb data", 32'(DB_OUT), 32'hAB);
      checkOutput("plan5 bp wrapped", 32'(BP_OUT), 32'h0);
      IOR_N = 1'b1; CS_N = 1'b1;
      tick();

      // Simultaneous write and read: write wins, pointer advances once
      regWrite(4'hC, 8'h00);
      ADDR_L = 4'h3; DB_IN = 8'h5A; CS_N = 1'b0; IOW_N = 1'b0; IOR_N = 1'b0;
      tick();
      checkOutput("simul bp", 32'(BP_OUT), 32'h1);
      checkOutput("simul no read", 32'(DB_OUT), 32'h00);
      IOW_N = 1'b1; IOR_N = 1'b1; CS_N = 1'b1;
      tick();
      regWrite(4'h3, 8'hA5);
      read16(4'h3, rd16);
      checkOutput("simul readback", 32'(rd16), 32'hA55A);

      // Master clear aborts partial sequence and zeros registers
      regWrite(4'hC, 8'h00);
      regWrite(4'h0, 8'h11);
      checkOutput("mclr bp before", 32'(BP_OUT), 32'h1);
      regWrite(4'hD, 8'h00);
      checkOutput("mclr bp after", 32'(BP_OUT), 32'h0);
      HLDA = 1'b1; ACT_CH = 2'd1;
      #1;
      checkOutput("mclr ch1 addr", 32'(ADDR_OUT), 32'h0);
      ACT_CH = 2'd2;
      #1;
      checkOutput("mclr ch2 addr", 32'(ADDR_OUT), 32'h0);
      HLDA = 1'b0;
      tick();

      // Async reset mid-sequence, then XFER with HLDA low
      program16(4'h2, 16'h7777);
      regWrite(4'hC, 8'h00);
      regWrite(4'h6, 8'h99);
      checkOutput("plan6 bp mid", 32'(BP_OUT), 32'h1);
      #2;
      RESET = 1'b1;
      #1;
      checkOutput("plan6 bp reset", 32'(BP_OUT), 32'h0);
      checkOutput("plan6 tc reset", 32'(TC), 32'h0);
      checkOutput("plan6 db reset", 32'(DB_OUT), 32'h0);
      HLDA = 1'b1; ACT_CH = 2'd1;
      #1;
      checkOutput("plan6 ch1 addr reset", 32'(ADDR_OUT), 32'h0);
      HLDA = 1'b0;
      tick();
      RESET = 1'b0;
      tick();
      program16(4'h2, 16'h0042);
      ACT_CH = 2'd1;
      pulseXfer();
      checkOutput("plan6 xfer hlda low tc", 32'(TC), 32'h0);
      HLDA = 1'b1;
      #1;
      checkOutput("plan6 xfer hlda low addr", 32'(ADDR_OUT), 32'h0042);
      HLDA = 1'b0;
      tick();

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i], i);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
